// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - shared types and constants for the Gray sequence checker
package gray_pkg;

  localparam int GRAY_W = 3;

  typedef enum logic [1:0] {
    ACQ    = 2'd0,
    TRACK  = 2'd1,
    ERR    = 2'd2,
    UNUSED = 2'd3
  } state_t;

endpackage

// File: rtl/gray_decode.sv
// rtl/gray_decode.sv - combinational Gray to binary decoder
module gray_decode
  import gray_pkg::*;
(
  input  logic [GRAY_W-1:0] Gray,
  output logic [GRAY_W-1:0] Binary
);

  // Each binary bit is the XOR reduction of the Gray bits at and above it
  always_comb begin
    Binary = '0;
    for (int i = 0; i < GRAY_W; i++) begin
      Binary[i] = ^(Gray >> i);
    end
  end

endmodule

// File: rtl/gray_checker.sv
// rtl/gray_checker.sv - forward-progression checker for a 3-bit Gray counter
module gray_checker
  import gray_pkg::*;
#(
  parameter int WRAP_W = 8,
  parameter int RELOCK = 4
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Clear,
  input  logic              Valid,
  input  logic [GRAY_W-1:0] Gray,
  input  logic              Ovf_in,
  output logic [GRAY_W-1:0] Binary,
  output logic              Locked,
  output logic              Step_err,
  output logic [WRAP_W-1:0] Wrap_cnt,
  output logic              Ovf_mismatch
);

  localparam logic [3:0] RELOCK_RUN = 4'(RELOCK);

  state_t              state, state_nxt;
  logic [GRAY_W-1:0]   last, last_nxt;
  logic [3:0]          run, run_nxt;
  logic                wrap_seen, wrap_seen_nxt;
  logic [WRAP_W-1:0]   wrap_cnt, wrap_cnt_nxt;
  logic                mismatch, mismatch_nxt;
  logic                step_err, step_err_nxt;
  logic                locked;

  logic [GRAY_W-1:0]   b;
  logic [GRAY_W-1:0]   last_inc;
  logic [3:0]          run_inc;
  logic                is_hold, is_good, is_wrap;

  gray_decode u_decode (
    .Gray   (Gray),
    .Binary (b)
  );

  assign last_inc = last + GRAY_W'(1);
  assign run_inc  = run + 4'd1;
  assign is_hold  = (b == last);
  assign is_good  = (b == last_inc);
  assign is_wrap  = (last == '1) && (b == '0);

  // State, reference and counter registers; Locked is registered from the next state
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= ACQ;
      last      <= '0;
      run       <= '0;
      wrap_seen <= 1'b0;
      wrap_cnt  <= '0;
      mismatch  <= 1'b0;
      step_err  <= 1'b0;
      locked    <= 1'b0;
    end else begin
      state     <= state_nxt;
      last      <= last_nxt;
      run       <= run_nxt;
      wrap_seen <= wrap_seen_nxt;
      wrap_cnt  <= wrap_cnt_nxt;
      mismatch  <= mismatch_nxt;
      step_err  <= step_err_nxt;
      locked    <= (state_nxt == TRACK);
    end
  end

  // Sample classification, FSM transitions, wrap counting and overflow cross-check
  always_comb begin
    state_nxt     = state;
    last_nxt      = last;
    run_nxt       = run;
    wrap_seen_nxt = wrap_seen;
    wrap_cnt_nxt  = wrap_cnt;
    mismatch_nxt  = mismatch;
    step_err_nxt  = 1'b0;

    if (Clear) begin
      state_nxt     = ACQ;
      run_nxt       = '0;
      wrap_seen_nxt = 1'b0;
      wrap_cnt_nxt  = '0;
      mismatch_nxt  = 1'b0;
    end else if (Valid) begin
      case (state)
        ACQ: begin
          last_nxt  = b;
          state_nxt = TRACK;
        end
        TRACK: begin
          // Any TRACK sample counts, including holds and bad steps
          if (!Ovf_in && (wrap_seen || is_wrap)) begin
            mismatch_nxt = 1'b1;
          end
          if (is_good) begin
            last_nxt = b;
            if (is_wrap) begin
              wrap_seen_nxt = 1'b1;
              if (wrap_cnt != '1) begin
                wrap_cnt_nxt = wrap_cnt + WRAP_W'(1);
              end
            end
          end else if (!is_hold) begin
            state_nxt    = ERR;
            step_err_nxt = 1'b1;
            last_nxt     = b;
            run_nxt      = '0;
          end
        end
        ERR: begin
          if (is_good) begin
            last_nxt = b;
            if (run_inc == RELOCK_RUN) begin
              state_nxt = TRACK;
              run_nxt   = '0;
            end else begin
              run_nxt = run_inc;
            end
          end else if (!is_hold) begin
            last_nxt = b;
            run_nxt  = '0;
          end
        end
        default: begin
          state_nxt = ACQ;
          run_nxt   = '0;
        end
      endcase
    end
  end

  assign Binary       = last;
  assign Locked       = locked;
  assign Step_err     = step_err;
  assign Wrap_cnt     = wrap_cnt;
  assign Ovf_mismatch = mismatch;

endmodule

// File: tb/tb_gray_checker.sv
// tb/tb_gray_checker.sv - directed self-checking bench for gray_checker
module tb_gray_checker;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b1;
  logic       Clear = 1'b0;
  logic       Valid = 1'b0;
  logic [2:0] Gray = 3'b000;
  logic       Ovf_in = 1'b0;
  logic [2:0] Binary;
  logic       Locked;
  logic       Step_err;
  logic [1:0] Wrap_cnt;
  logic       Ovf_mismatch;

  int total = 0;
  int bad = 0;

  logic [2:0] gray_of [8] = '{3'b000, 3'b001, 3'b011, 3'b010,
                              3'b110, 3'b111, 3'b101, 3'b100};

  always #5 Clk = ~Clk;

  gray_checker #(.WRAP_W(2), .RELOCK(4)) dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .Clear        (Clear),
    .Valid        (Valid),
    .Gray         (Gray),
    .Ovf_in       (Ovf_in),
    .Binary       (Binary),
    .Locked       (Locked),
    .Step_err     (Step_err),
    .Wrap_cnt     (Wrap_cnt),
    .Ovf_mismatch (Ovf_mismatch)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [2:0] bin, input logic lk,
                         input logic se, input logic [1:0] wc, input logic om);
    chk({tag, ".binary"}, 32'(Binary), 32'(bin));
    chk({tag, ".locked"}, 32'(Locked), 32'(lk));
    chk({tag, ".step_err"}, 32'(Step_err), 32'(se));
    chk({tag, ".wrap_cnt"}, 32'(Wrap_cnt), 32'(wc));
    chk({tag, ".ovf_mismatch"}, 32'(Ovf_mismatch), 32'(om));
  endtask

  task automatic step(input logic [2:0] b, input logic ovf);
    Valid  = 1'b1;
    Gray   = gray_of[b];
    Ovf_in = ovf;
    @(posedge Clk);
    #1;
    Valid = 1'b0;
  endtask

  task automatic idle();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    int wraps;
    logic [2:0] bv;

    // async reset before any clock edge
    #1 Reset_n = 1'b0;
    #2;
    chk_all("reset_async", 3'd0, 1'b0, 1'b0, 2'd0, 1'b0);
    idle();
    idle();
    chk_all("reset_held", 3'd0, 1'b0, 1'b0, 2'd0, 1'b0);
    Reset_n = 1'b1;
    idle();

    // full cycle 0..7,0 with overflow rising on the wrap
    step(3'd0, 1'b0);
    chk_all("cyc_acq", 3'd0, 1'b1, 1'b0, 2'd0, 1'b0);
    for (int i = 1; i < 8; i++) begin
      step(3'(i), 1'b0);
      chk_all("cyc_step", 3'(i), 1'b1, 1'b0, 2'd0, 1'b0);
    end
    step(3'd0, 1'b1);
    chk_all("cyc_wrap", 3'd0, 1'b1, 1'b0, 2'd1, 1'b0);

    // skip from 2 to 5, then relock after four good steps
    step(3'd1, 1'b1);
    step(3'd2, 1'b1);
    chk_all("skip_pre", 3'd2, 1'b1, 1'b0, 2'd1, 1'b0);
    step(3'd5, 1'b1);
    chk_all("skip_err", 3'd5, 1'b0, 1'b1, 2'd1, 1'b0);
    idle();
    chk_all("skip_pulse_end", 3'd5, 1'b0, 1'b0, 2'd1, 1'b0);
    step(3'd6, 1'b1);
    chk_all("skip_g1", 3'd6, 1'b0, 1'b0, 2'd1, 1'b0);
    step(3'd7, 1'b1);
    chk_all("skip_g2", 3'd7, 1'b0, 1'b0, 2'd1, 1'b0);
    step(3'd0, 1'b1);
    chk_all("skip_g3_nowrap", 3'd0, 1'b0, 1'b0, 2'd1, 1'b0);
    step(3'd1, 1'b1);
    chk_all("skip_relock", 3'd1, 1'b1, 1'b0, 2'd1, 1'b0);

    // backward step 4 -> 3, holds, bad on the relock edge
    step(3'd2, 1'b1);
    step(3'd3, 1'b1);
    step(3'd4, 1'b1);
    chk_all("back_pre", 3'd4, 1'b1, 1'b0, 2'd1, 1'b0);
    step(3'd3, 1'b1);
    chk_all("back_err", 3'd3, 1'b0, 1'b1, 2'd1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(3'd3, 1'b1);
      chk_all("back_hold", 3'd3, 1'b0, 1'b0, 2'd1, 1'b0);
    end
    for (int i = 4; i < 7; i++) begin
      step(3'(i), 1'b1);
      chk_all("back_run", 3'(i), 1'b0, 1'b0, 2'd1, 1'b0);
    end
    step(3'd1, 1'b1);
    chk_all("back_bad_at_relock", 3'd1, 1'b0, 1'b0, 2'd1, 1'b0);
    for (int i = 2; i < 5; i++) begin
      step(3'(i), 1'b1);
      chk_all("back_rerun", 3'(i), 1'b0, 1'b0, 2'd1, 1'b0);
    end
    step(3'd5, 1'b1);
    chk_all("back_relock", 3'd5, 1'b1, 1'b0, 2'd1, 1'b0);

    // missing overflow on a 7 -> 0 step, sticky, then Clear with Valid
    step(3'd6, 1'b1);
    step(3'd7, 1'b1);
    step(3'd0, 1'b0);
    chk_all("ovf_miss", 3'd0, 1'b1, 1'b0, 2'd2, 1'b1);
    for (int i = 1; i <= 10; i++) begin
      step(3'(i % 8), 1'b1);
      chk("ovf_sticky", 32'(Ovf_mismatch), 32'd1);
    end
    chk("ovf_wrap_sat", 32'(Wrap_cnt), 32'd3);
    Clear  = 1'b1;
    Valid  = 1'b1;
    Gray   = gray_of[5];
    Ovf_in = 1'b1;
    @(posedge Clk);
    #1;
    Clear = 1'b0;
    Valid = 1'b0;
    chk("clr_locked", 32'(Locked), 32'd0);
    chk("clr_step_err", 32'(Step_err), 32'd0);
    chk("clr_wrap_cnt", 32'(Wrap_cnt), 32'd0);
    chk("clr_ovf_mismatch", 32'(Ovf_mismatch), 32'd0);
    step(3'd3, 1'b1);
    chk_all("clr_reacq", 3'd3, 1'b1, 1'b0, 2'd0, 1'b0);

    // saturation over five full cycles
    wraps = 0;
    for (int k = 1; k <= 40; k++) begin
      bv = 3'((3 + k) % 8);
      step(bv, 1'b1);
      if (bv == 3'd0) begin
        wraps++;
        chk("sat_wrap_cnt", 32'(Wrap_cnt), (wraps > 3) ? 32'd3 : 32'(wraps));
      end
    end
    chk_all("sat_end", 3'd3, 1'b1, 1'b0, 2'd3, 1'b0);

    // async reset while in ERR with Step_err high
    step(3'd6, 1'b1);
    chk_all("rst_err", 3'd6, 1'b0, 1'b1, 2'd3, 1'b0);
    #2 Reset_n = 1'b0;
    #1;
    chk_all("rst_mid", 3'd0, 1'b0, 1'b0, 2'd0, 1'b0);
    idle();
    Reset_n = 1'b1;
    step(3'd4, 1'b1);
    chk_all("rst_reacq", 3'd4, 1'b1, 1'b0, 2'd0, 1'b0);
    step(3'd5, 1'b1);
    chk_all("rst_good", 3'd5, 1'b1, 1'b0, 2'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
